// File: rtl/debouncer.sv
// Debouncer: synchronises a raw asynchronous level into clk, qualifies it for
// STABLE_CYCLES consecutive samples before committing it to out, and counts rejected glitches.
module debouncer #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 16,
    parameter logic        INIT          = 1'b0,
    parameter int unsigned GW            = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in,
    input  logic          clr,
    output logic          out,
    output logic          pending,
    output logic [GW-1:0] glitch_cnt
);

    localparam int unsigned   CW   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("debouncer: SYNC_STAGES must be >= 2");
    end
    if (STABLE_CYCLES < 2) begin : g_bad_stable
        $error("debouncer: STABLE_CYCLES must be >= 2");
    end

    typedef enum logic {
        STABLE,
        CHECK
    } state_t;

    state_t                 state, state_nx;
    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt, cnt_nx;
    logic                   out_nx;
    logic                   reject;
    logic [GW-1:0]          glitch_nx;
    logic                   s;

    assign s       = sync[SYNC_STAGES-1];
    assign pending = (state == CHECK);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= {SYNC_STAGES{INIT}};
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], in};
        end
    end

    // cnt holds the number of differing samples already seen, so the commit
    // fires on the sample that brings the run to STABLE_CYCLES.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        out_nx   = out;
        reject   = 1'b0;
        case (state)
            STABLE: begin
                if (s != out) begin
                    state_nx = CHECK;
                    cnt_nx   = CW'(1);
                end else begin
                    cnt_nx = '0;
                end
            end
            CHECK: begin
                if (s != out) begin
                    if (cnt == LAST) begin
                        out_nx   = s;
                        state_nx = STABLE;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end else begin
                    state_nx = STABLE;
                    cnt_nx   = '0;
                    reject   = 1'b1;
                end
            end
            default: begin
                state_nx = STABLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_comb begin
        glitch_nx = glitch_cnt;
        if (clr) begin
            glitch_nx = '0;
        end else if (reject && (glitch_cnt != '1)) begin
            glitch_nx = glitch_cnt + GW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= STABLE;
            cnt        <= '0;
            out        <= INIT;
            glitch_cnt <= '0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            out        <= out_nx;
            glitch_cnt <= glitch_nx;
        end
    end

endmodule

// File: tb/tb_debouncer.sv
// Bench for debouncer: two instances (INIT=0 and INIT=1) checked every cycle against
// a run-length model of the synchronised input, plus directed literal checks.
module tb_debouncer;

    localparam int unsigned S    = 2;
    localparam int unsigned N    = 4;
    localparam int unsigned GMAX = 3;

    logic       clk;
    logic       rst;
    logic       clr;
    logic       in0, in1;
    logic       out0, out1;
    logic       pending0, pending1;
    logic [1:0] glitch0, glitch1;

    int errors = 0;
    int checks = 0;

    debouncer #(.SYNC_STAGES(S), .STABLE_CYCLES(N), .INIT(1'b0), .GW(2)) dut0 (
        .clk(clk), .rst(rst), .in(in0), .clr(clr),
        .out(out0), .pending(pending0), .glitch_cnt(glitch0)
    );

    debouncer #(.SYNC_STAGES(S), .STABLE_CYCLES(N), .INIT(1'b1), .GW(2)) dut1 (
        .clk(clk), .rst(rst), .in(in1), .clr(clr),
        .out(out1), .pending(pending1), .glitch_cnt(glitch1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the filter sees the input delayed by S samples; a run of differing
    // samples reaching N commits, a run broken early is a rejected glitch.
    bit hist [2][S];
    bit out_m [2];
    int diff_run [2];
    int glit_m [2];
    bit mvalid = 1'b0;

    always @(posedge clk) begin
        bit iv, initv, sv, rej;
        for (int d = 0; d < 2; d++) begin
            iv    = (d == 0) ? in0 : in1;
            initv = (d == 0) ? 1'b0 : 1'b1;
            if (rst) begin
                for (int j = 0; j < S; j++) hist[d][j] = initv;
                out_m[d]    = initv;
                diff_run[d] = 0;
                glit_m[d]   = 0;
            end else begin
                sv  = hist[d][S-1];
                rej = 1'b0;
                if (sv != out_m[d]) begin
                    diff_run[d]++;
                    if (diff_run[d] == N) begin
                        out_m[d]    = sv;
                        diff_run[d] = 0;
                    end
                end else if (diff_run[d] > 0) begin
                    rej         = 1'b1;
                    diff_run[d] = 0;
                end
                if (clr) glit_m[d] = 0;
                else if (rej && glit_m[d] < GMAX) glit_m[d]++;
                for (int j = S - 1; j > 0; j--) hist[d][j] = hist[d][j-1];
                hist[d][0] = iv;
            end
        end
        if (rst) mvalid = 1'b1;
    end

    always @(negedge clk) begin
        if (mvalid) begin
            chk("model out0", out0, out_m[0]);
            chk("model pending0", pending0, diff_run[0] > 0);
            chk("model glitch0", glitch0, glit_m[0]);
            chk("model out1", out1, out_m[1]);
            chk("model pending1", pending1, diff_run[1] > 0);
            chk("model glitch1", glitch1, glit_m[1]);
        end
    end

    bit prev_p0 = 1'b0;
    int rises0  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (pending0 && !prev_p0) rises0++;
        prev_p0 = pending0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int r0;
        int pend1_cycles;
        rst = 1'b1;
        clr = 1'b0;
        in0 = 1'b1;
        in1 = 1'b0;

        // Reset held two cycles with in driven away from INIT
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst out0", out0, 0);
            chk("rst pending0", pending0, 0);
            chk("rst glitch0", glitch0, 0);
            chk("rst out1", out1, 1);
        end
        rst = 1'b0;

        // Rise on dut0 and fall on dut1 land exactly S+N-1 = 5 edges after first sampling edge
        pend1_cycles = 0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (pending1) pend1_cycles++;
            if (i == 5) begin
                chk("latency out0 early", out0, 0);
                chk("latency out1 early", out1, 1);
            end
            if (i == 6) begin
                chk("latency out0 rise", out0, 1);
                chk("latency out1 fall", out1, 0);
            end
        end
        chk("fall pending window", pend1_cycles, 3);

        in0 = 1'b0;
        ticks(8);
        chk("return out0", out0, 0);

        // Bounce 1,0,1,0
        r0 = rises0;
        in0 = 1'b1; tick();
        in0 = 1'b0; tick();
        in0 = 1'b1; tick();
        in0 = 1'b0; tick();
        ticks(6);
        chk("bounce out0", out0, 0);
        chk("bounce glitch0", glitch0, 2);
        chk("bounce pending pulses", rises0 - r0, 2);

        // Threshold: 3 samples rejected, 4 samples commit
        in0 = 1'b1; ticks(3);
        in0 = 1'b0; ticks(6);
        chk("thr3 out0", out0, 0);
        chk("thr3 glitch0", glitch0, 3);
        in0 = 1'b1; ticks(4);
        in0 = 1'b0; ticks(2);
        chk("thr4 out0", out0, 1);
        chk("thr4 glitch0", glitch0, 3);
        ticks(6);
        chk("thr4 return out0", out0, 0);

        // Saturation with GW=2, then clr colliding with a rejection
        clr = 1'b1; tick();
        clr = 1'b0;
        chk("clr glitch0", glitch0, 0);
        for (int g = 1; g <= 5; g++) begin
            in0 = 1'b1; tick();
            in0 = 1'b0; ticks(3);
            chk("sat glitch0", glitch0, (g < 3) ? g : 3);
        end
        in0 = 1'b1; tick();
        in0 = 1'b0; ticks(2);
        chk("pre-clr pending0", pending0, 1);
        clr = 1'b1; tick();
        clr = 1'b0;
        chk("clr wins glitch0", glitch0, 0);

        // Reset mid-CHECK after a fresh glitch, dut1 sitting away from INIT
        in0 = 1'b1; tick();
        in0 = 1'b0; ticks(4);
        chk("pre-rst glitch0", glitch0, 1);
        in0 = 1'b1; ticks(4);
        chk("mid-check pending0", pending0, 1);
        chk("pre-rst out1", out1, 0);
        rst = 1'b1; tick();
        rst = 1'b0;
        chk("rst mid pending0", pending0, 0);
        chk("rst mid out0", out0, 0);
        chk("rst mid glitch0", glitch0, 0);
        chk("rst mid out1", out1, 1);
        in0 = 1'b0;
        ticks(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
